id_ex_register: RTL

ID_EX_REGISTER -- requirements
Module: id_ex_register

---
 rtl/id_ex_register_pkg.sv | 37 +++
 rtl/id_ex_register_sat_counter.sv | 19 +
 rtl/id_ex_register.sv | 109 ++++++++++
 3 files changed

// File: rtl/id_ex_register_pkg.sv
// rtl/id_ex_register_pkg.sv - shared widths, control-word layout and ALU encodings for the ID/EX register
package id_ex_register_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;
    localparam int ALU_OP_W  = 4;
    localparam int CTRL_W    = 8;

    // Control-word bit positions; bit 7 marks an injected bubble
    localparam int CTRL_REG_WRITE  = 0;
    localparam int CTRL_MEM_READ   = 1;
    localparam int CTRL_MEM_WRITE  = 2;
    localparam int CTRL_BRANCH     = 3;
    localparam int CTRL_JUMP       = 4;
    localparam int CTRL_ALU_SRC    = 5;
    localparam int CTRL_MEM_TO_REG = 6;
    localparam int CTRL_BUBBLE     = 7;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SLL  = 4'h5,
        ALU_SRL  = 4'h6,
        ALU_SRA  = 4'h7,
        ALU_SLT  = 4'h8,
        ALU_SLTU = 4'h9
    } alu_op_e;

    typedef enum logic {
        OCC_EMPTY = 1'b0,
        OCC_FULL  = 1'b1
    } occ_state_e;

endpackage

// File: rtl/id_ex_register_sat_counter.sv
// rtl/id_ex_register_sat_counter.sv - saturating event counter with synchronous active-low reset
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/id_ex_register.sv
// rtl/id_ex_register.sv - ID/EX pipeline register with hold/flush, occupancy FSM and bubble/flush counters
module id_ex_register
    import id_ex_register_pkg::*;
#(
    parameter int XLEN  = id_ex_register_pkg::XLEN,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 hold,
    input  logic                 flush,
    input  logic                 i_valid,
    input  logic [ALU_OP_W-1:0]  i_alu_op,
    input  logic [CTRL_W-1:0]    i_control_unit_signal,
    input  logic [XLEN-1:0]      i_pc,
    input  logic [XLEN-1:0]      i_rs1_data,
    input  logic [XLEN-1:0]      i_rs2_data,
    input  logic [XLEN-1:0]      i_imm,
    input  logic [REG_IDX_W-1:0] i_rs1,
    input  logic [REG_IDX_W-1:0] i_rs2,
    input  logic [REG_IDX_W-1:0] i_rd,
    output logic [ALU_OP_W-1:0]  o_alu_op,
    output logic [CTRL_W-1:0]    o_control_unit_signal,
    output logic [XLEN-1:0]      o_pc,
    output logic [XLEN-1:0]      o_rs1_data,
    output logic [XLEN-1:0]      o_rs2_data,
    output logic [XLEN-1:0]      o_imm,
    output logic [REG_IDX_W-1:0] o_rs1,
    output logic [REG_IDX_W-1:0] o_rs2,
    output logic [REG_IDX_W-1:0] o_rd,
    output logic                 o_valid,
    output logic [CNT_W-1:0]     o_bubble_cnt,
    output logic [CNT_W-1:0]     o_flush_cnt
);

    occ_state_e state_q, state_d;
    logic       load_en;
    logic       valid_d;
    logic       bubble_inc;
    logic       flush_inc;

    always_comb begin
        state_d = state_q;
        load_en = 1'b0;
        valid_d = i_valid && (i_control_unit_signal != '0);
        if (flush) begin
            state_d = OCC_EMPTY;
        end else if (!hold) begin
            load_en = 1'b1;
            state_d = valid_d ? OCC_FULL : OCC_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= OCC_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    assign o_valid = (state_q == OCC_FULL);

    // Control word is zeroed whenever the slot is empty so EX never acts on a dead entry
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_alu_op              <= '0;
            o_control_unit_signal <= '0;
            o_pc                  <= '0;
            o_rs1_data            <= '0;
            o_rs2_data            <= '0;
            o_imm                 <= '0;
            o_rs1                 <= '0;
            o_rs2                 <= '0;
            o_rd                  <= '0;
        end else if (flush) begin
            o_alu_op              <= '0;
            o_control_unit_signal <= '0;
        end else if (load_en) begin
            o_alu_op              <= i_alu_op;
            o_control_unit_signal <= valid_d ? i_control_unit_signal : '0;
            o_pc                  <= i_pc;
            o_rs1_data            <= i_rs1_data;
            o_rs2_data            <= i_rs2_data;
            o_imm                 <= i_imm;
            o_rs1                 <= i_rs1;
            o_rs2                 <= i_rs2;
            o_rd                  <= i_rd;
        end
    end

    assign bubble_inc = flush || (load_en && !valid_d);
    assign flush_inc  = flush && (state_q == OCC_FULL);

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bubble_inc),
        .count (o_bubble_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .count (o_flush_cnt)
    );

endmodule
